// File: rtl/key_encoder_pkg.sv
// key_pkg: shared types and helpers for the push-button encoder.
//   key_state_e  : FSM state encoding
//   KEY_IDLE_N   : level of the active-low key lines with nothing pressed
//   prienc8      : index of the highest set bit (0 when none set)
//   popcnt_gt1   : 1 when more than one bit is set
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } key_state_e;

  localparam logic [7:0] KEY_IDLE_N = 8'hff;

  function automatic logic [2:0] prienc8(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcnt_gt1(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/key_encoder_if.sv
// key_encoder_if: button-side inputs and encoded outputs of key_encoder.
//   en, key_n              : driven by the master (board/control side)
//   code, valid, pressed,
//   multi                  : driven by the slave (key_encoder)
interface key_encoder_if;
  logic       en;
  logic [7:0] key_n;
  logic [2:0] code;
  logic       valid;
  logic       pressed;
  logic       multi;

  modport master (
    output en,
    output key_n,
    input  code,
    input  valid,
    input  pressed,
    input  multi
  );

  modport slave (
    input  en,
    input  key_n,
    output code,
    output valid,
    output pressed,
    output multi
  );
endinterface

// File: rtl/key_sync.sv
// key_sync: two-flop synchroniser for asynchronous level inputs.
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input bus (W bits)
//   q        : synchronised output, RST_VAL while in reset
module key_sync #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RST_VAL;
      q     <= RST_VAL;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// key_encoder: synchronises and debounces 8 active-low push buttons,
// priority-encodes the pressed key and pulses valid once per accepted press.
//   clk, rst    : clock, asynchronous active-high reset
//   bus.en      : enable; low returns the FSM to IDLE (code/multi hold)
//   bus.key_n   : raw active-low button lines, asynchronous to clk
//   bus.code    : highest-numbered key down at acceptance
//   bus.valid   : one-cycle pulse per accepted press
//   bus.pressed : high from accepted press until accepted release
//   bus.multi   : more than one key down at acceptance
module key_encoder
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  key_encoder_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync_n;
  logic [7:0]       raw;
  logic             any;
  logic [7:0]       snap;
  logic [CNT_W-1:0] cnt;
  key_state_e       state;
  logic [2:0]       code_r;
  logic             valid_r;
  logic             pressed_r;
  logic             multi_r;

  key_sync #(
    .W       (8),
    .RST_VAL (KEY_IDLE_N)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.key_n),
    .q   (sync_n)
  );

  assign raw = ~sync_n;
  assign any = |raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      cnt       <= '0;
      code_r    <= '0;
      valid_r   <= 1'b0;
      pressed_r <= 1'b0;
      multi_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (!bus.en) begin
        state     <= IDLE;
        pressed_r <= 1'b0;
        cnt       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (any) begin
              state <= DEBOUNCE;
              snap  <= raw;
              cnt   <= '0;
            end
          end
          DEBOUNCE: begin
            if (!any) begin
              state <= IDLE;
            end else if (raw != snap) begin
              snap <= raw;
              cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
              state     <= PRESSED;
              valid_r   <= 1'b1;
              pressed_r <= 1'b1;
              code_r    <= prienc8(snap);
              multi_r   <= popcnt_gt1(snap);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            // Changes among held keys are ignored: no rollover to a new code.
            if (!any) begin
              state <= RELEASE;
              cnt   <= '0;
            end
          end
          RELEASE: begin
            if (any) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state     <= IDLE;
              pressed_r <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.code    = code_r;
  assign bus.valid   = valid_r;
  assign bus.pressed = pressed_r;
  assign bus.multi   = multi_r;

endmodule

// File: tb/tb_key_encoder.sv
module tb_key_encoder;

  typedef struct {
    logic [2:0] code;
    logic       multi;
  } exp_t;

  typedef struct {
    logic [7:0]  key_n;
    int unsigned hold;
    logic        exp_valid;
    logic [2:0]  code;
    logic        multi;
  } vec_t;

  logic clk;
  logic rst;
  key_encoder_if bus();

  key_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   bad;
  int   valid_cnt;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then score any valid pulse.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.valid !== 1'b0) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_code", 32'(bus.code), 32'(e.code));
        check("sb_multi", 32'(bus.multi), 32'(e.multi));
      end
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [2:0] c, input logic m);
    exp_t e;
    e.code  = c;
    e.multi = m;
    exp_q.push_back(e);
  endtask

  vec_t vecs[$];

  initial begin
    int start_cnt;
    total     = 0;
    bad       = 0;
    valid_cnt = 0;
    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.key_n = 8'h00;

    // Reset holds all outputs low even with every key down.
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("rst_code", 32'(bus.code), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_pressed", 32'(bus.pressed), 32'd0);
      check("rst_multi", 32'(bus.multi), 32'd0);
    end
    bus.key_n = 8'hff;
    tick();
    rst = 1'b0;
    ticks(4);

    // Press latency: valid exactly after edge 7.
    bus.key_n = 8'hf7;
    push(3'd3, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("lat_valid_e%0d", k), 32'(bus.valid), 32'(k == 7));
      check($sformatf("lat_pressed_e%0d", k), 32'(bus.pressed), 32'(k >= 7));
    end
    check("lat_code", 32'(bus.code), 32'd3);
    check("lat_multi", 32'(bus.multi), 32'd0);
    // Release latency: pressed falls after edge 7.
    bus.key_n = 8'hff;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("rel_pressed_e%0d", k), 32'(bus.pressed), 32'(k < 7));
    end

    // Table-driven presses, including the D+1-cycle acceptance boundary.
    vecs.push_back('{8'h5a, 12, 1'b1, 3'd7, 1'b1});
    vecs.push_back('{8'hfe, 12, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{8'h7f, 12, 1'b1, 3'd7, 1'b0});
    vecs.push_back('{8'hf3, 12, 1'b1, 3'd3, 1'b1});
    vecs.push_back('{8'h00, 12, 1'b1, 3'd7, 1'b1});
    vecs.push_back('{8'hfd,  1, 1'b0, 3'd7, 1'b1});
    vecs.push_back('{8'hfd,  3, 1'b0, 3'd7, 1'b1});
    vecs.push_back('{8'hef,  4, 1'b0, 3'd7, 1'b1});
    vecs.push_back('{8'hef,  5, 1'b1, 3'd4, 1'b0});
    vecs.push_back('{8'hbf,  8, 1'b1, 3'd6, 1'b0});
    foreach (vecs[i]) begin
      start_cnt = valid_cnt;
      bus.key_n = vecs[i].key_n;
      if (vecs[i].exp_valid) push(vecs[i].code, vecs[i].multi);
      ticks(vecs[i].hold);
      bus.key_n = 8'hff;
      ticks(12);
      check($sformatf("vec%0d_valids", i), 32'(valid_cnt - start_cnt), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("vec%0d_pressed", i), 32'(bus.pressed), 32'd0);
      check($sformatf("vec%0d_code_hold", i), 32'(bus.code), 32'(vecs[i].code));
      check($sformatf("vec%0d_multi_hold", i), 32'(bus.multi), 32'(vecs[i].multi));
    end

    // Bouncy press then bouncy release: exactly one valid.
    start_cnt = valid_cnt;
    push(3'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.key_n = (i % 2 == 0) ? 8'hf7 : 8'hff;
      tick();
    end
    bus.key_n = 8'hf7;
    ticks(12);
    check("bounce_press_pressed", 32'(bus.pressed), 32'd1);
    bus.key_n = 8'hff;
    ticks(2);
    for (int i = 0; i < 6; i++) begin
      bus.key_n = (i % 2 == 0) ? 8'hf7 : 8'hff;
      tick();
    end
    bus.key_n = 8'hff;
    ticks(12);
    check("bounce_valids", 32'(valid_cnt - start_cnt), 32'd1);
    check("bounce_code", 32'(bus.code), 32'd3);
    check("bounce_released", 32'(bus.pressed), 32'd0);

    // Reset mid-debounce aborts the press.
    start_cnt = valid_cnt;
    bus.key_n = 8'hfb;
    ticks(4);
    rst = 1'b1;
    tick();
    check("rstmid_valid", 32'(bus.valid), 32'd0);
    check("rstmid_code", 32'(bus.code), 32'd0);
    bus.key_n = 8'hff;
    ticks(2);
    rst = 1'b0;
    ticks(12);
    check("rstmid_valids", 32'(valid_cnt - start_cnt), 32'd0);

    // en=0 while pressed, then re-enable with key still held.
    bus.key_n = 8'hf7;
    push(3'd3, 1'b0);
    ticks(12);
    check("en_pressed", 32'(bus.pressed), 32'd1);
    bus.en = 1'b0;
    tick();
    check("en_off_pressed", 32'(bus.pressed), 32'd0);
    check("en_off_code", 32'(bus.code), 32'd3);
    ticks(4);
    check("en_off_idle", 32'(bus.pressed), 32'd0);
    bus.en = 1'b1;
    push(3'd3, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("en_on_valid_e%0d", k), 32'(bus.valid), 32'(k == 5));
    end
    bus.key_n = 8'hff;
    ticks(12);
    check("en_released", 32'(bus.pressed), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
